round_timer_ctrl: RTL and testbench
===================================

ROUND_TIMER_CTRL -- requirements
Module: round_timer_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 6, bit width of the time limit and the remaining count.
REQ-002 SHALL have parameter DEFAULT_LIMIT, default 32, the value loaded when time_limit is 0.
REQ-003 SHALL have one clock and reset; reset is asynchronous and active-high.
REQ-004 SHALL have ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- second_tick, input, 1, one-cycle pulse per elapsed second from the rate divider.
- start, input, 1, load the limit and begin or restart the round.
- pause, input, 1, level; freezes the countdown while high.
- ack, input, 1, game FSM acknowledges expiry.
- time_limit, input, WIDTH, round length in seconds.
- remaining, output, WIDTH, seconds left.
- tens, output, 4, BCD tens digit of remaining.
- units, output, 4, BCD units digit of remaining.
- running, output, 1, high in RUNNING.
- expired, output, 1, high in EXPIRED.
- timeout_pulse, output, 1, one-cycle pulse on expiry.

Function
REQ-005 SHALL implement a state machine with states IDLE, RUNNING, PAUSED and EXPIRED.
REQ-006 SHALL give input priority start > pause > second_tick in every state.
REQ-007 SHALL, on start in any state, load remaining with time_limit (DEFAULT_LIMIT if time_limit is 0) at the next edge and enter RUNNING.
REQ-008 SHALL drop any second_tick that coincides with start.
REQ-009 SHALL, in RUNNING with pause high, enter PAUSED with remaining unchanged and the tick ignored.
REQ-010 SHALL, in PAUSED, ignore second_tick and return to RUNNING when pause is low; a tick in the release cycle is ignored.
REQ-011 SHALL, in RUNNING with second_tick high and remaining > 1, decrement remaining by 1 at the next edge.
REQ-012 SHALL, in RUNNING with second_tick high and remaining == 1, set remaining to 0, enter EXPIRED and assert timeout_pulse for exactly that one cycle.
REQ-013 SHALL never decrement remaining below 0 (no wrap-around).
REQ-014 SHALL hold expired high and remaining at 0 in EXPIRED until ack or start.
REQ-015 SHALL, on ack in EXPIRED without start, enter IDLE with remaining 0.
REQ-016 SHALL ignore ack outside EXPIRED, and ignore second_tick and pause in IDLE.
REQ-017 SHALL register outputs tens and units, updated on the same edge as remaining, with tens*10+units == remaining at all times (range 0..63).
REQ-018 SHALL drive running and expired as registered decodes of the state.
REQ-019 SHALL take effect one cycle after the input: remaining, state and timeout_pulse change at the edge that samples the input.

Reset
REQ-020 SHALL, on reset asserted, immediately force state IDLE, remaining 0, tens 0, units 0, running 0, expired 0 and timeout_pulse 0.
REQ-021 SHALL abort any round in progress on reset mid-operation and produce no timeout_pulse.
REQ-022 SHALL require a new start after reset deasserts before counting resumes.

Structure
REQ-023 SHALL place the state encoding typedef (IDLE, RUNNING, PAUSED, EXPIRED) and DEFAULT_LIMIT in the shared hangman package, alongside the rate-divider period constants.
REQ-024 SHALL use one sub-module, bcd_split, for the combinational WIDTH-to-two-digit BCD conversion.
REQ-025 SHALL keep the state machine and the counter register in round_timer_ctrl.

Verification
REQ-026 SHALL cover: time_limit=5, start, 5 ticks -> remaining 4,3,2,1,0; timeout_pulse high exactly one cycle after 5th tick; expired=1.
REQ-027 SHALL cover: time_limit=0, start -> remaining=32, tens=3, units=2.
REQ-028 SHALL cover: time_limit=10, start, 3 ticks, pause high, 4 ticks, pause low, 1 tick -> remaining 7 during pause, then 6.
REQ-029 SHALL cover: start and second_tick in same cycle with time_limit=20 -> remaining=20; start during RUNNING at 3 -> remaining reloads to 20.
REQ-030 SHALL cover: EXPIRED, ack -> IDLE, remaining 0, expired 0; further ticks -> no change.
REQ-031 SHALL cover: reset asserted mid-round at remaining=2 between clock edges -> all outputs 0 immediately, no timeout_pulse after release.

Source files
------------

// File: rtl/hangman_pkg.sv
// rtl/hangman_pkg.sv - shared hangman constants: round timer states, default limit, rate divider periods
package hangman_pkg;

    // Round timer state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_RUNNING = 2'd1;
    localparam state_t ST_PAUSED  = 2'd2;
    localparam state_t ST_EXPIRED = 2'd3;

    // Round length used when the configured time_limit is 0
    localparam int DEFAULT_LIMIT_C = 32;

    // Rate divider: one second_tick per TICK_PERIOD clocks
    localparam int CLK_HZ      = 50_000_000;
    localparam int TICK_PERIOD = CLK_HZ;
    localparam int TICK_CNT_W  = $clog2(TICK_PERIOD);

endpackage

// File: rtl/bcd_split.sv
// rtl/bcd_split.sv - combinational split of a binary count into two BCD digits
// Ports:
//   value : binary input, 0..99 expected
//   tens  : BCD tens digit
//   units : BCD units digit
module bcd_split #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] value,
    output logic [3:0]       tens,
    output logic [3:0]       units
);

    always_comb begin
        tens  = 4'(value / WIDTH'(10));
        units = 4'(value % WIDTH'(10));
    end

endmodule

// File: rtl/round_timer_ctrl.sv
// rtl/round_timer_ctrl.sv - per-round countdown timer with pause, expiry pulse and BCD display digits
// Ports:
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   second_tick       : one-cycle pulse per elapsed second
//   start             : load limit and (re)start the round
//   pause             : level, freezes the countdown
//   ack               : acknowledges expiry
//   time_limit        : round length in seconds (0 selects DEFAULT_LIMIT)
//   remaining         : seconds left
//   tens, units       : BCD digits of remaining
//   running, expired  : state decodes
//   timeout_pulse     : one-cycle pulse when the count reaches 0
module round_timer_ctrl
    import hangman_pkg::*;
#(
    parameter int WIDTH         = 6,
    parameter int DEFAULT_LIMIT = DEFAULT_LIMIT_C
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             second_tick,
    input  logic             start,
    input  logic             pause,
    input  logic             ack,
    input  logic [WIDTH-1:0] time_limit,
    output logic [WIDTH-1:0] remaining,
    output logic [3:0]       tens,
    output logic [3:0]       units,
    output logic             running,
    output logic             expired,
    output logic             timeout_pulse
);

    localparam logic [WIDTH-1:0] LOAD_DEFAULT = WIDTH'(DEFAULT_LIMIT);
    localparam logic [WIDTH-1:0] ONE          = WIDTH'(1);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] remaining_n;
    logic             pulse_n;
    logic [3:0]       tens_n;
    logic [3:0]       units_n;

    // start wins over everything, then pause, then second_tick
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        pulse_n     = 1'b0;
        if (start) begin
            state_n     = ST_RUNNING;
            remaining_n = (time_limit == '0) ? LOAD_DEFAULT : time_limit;
        end else begin
            case (state)
                ST_RUNNING: begin
                    if (pause) begin
                        state_n = ST_PAUSED;
                    end else if (second_tick) begin
                        if (remaining > ONE) begin
                            remaining_n = remaining - ONE;
                        end else begin
                            // last second (or a degenerate zero load) ends the round
                            remaining_n = '0;
                            state_n     = ST_EXPIRED;
                            pulse_n     = 1'b1;
                        end
                    end
                end
                ST_PAUSED: begin
                    // release cycle only resumes; a coincident tick is dropped
                    if (!pause) begin
                        state_n = ST_RUNNING;
                    end
                end
                ST_EXPIRED: begin
                    if (ack) begin
                        state_n     = ST_IDLE;
                        remaining_n = '0;
                    end
                end
                default: begin
                    state_n = state;
                end
            endcase
        end
    end

    // Digits are derived from the next count so they land on the same edge
    bcd_split #(
        .WIDTH (WIDTH)
    ) u_bcd_split (
        .value (remaining_n),
        .tens  (tens_n),
        .units (units_n)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            remaining     <= '0;
            tens          <= 4'd0;
            units         <= 4'd0;
            running       <= 1'b0;
            expired       <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            remaining     <= remaining_n;
            tens          <= tens_n;
            units         <= units_n;
            running       <= (state_n == ST_RUNNING);
            expired       <= (state_n == ST_EXPIRED);
            timeout_pulse <= pulse_n;
        end
    end

endmodule

// File: tb/tb_round_timer_ctrl.sv
// tb/tb_round_timer_ctrl.sv - self-checking bench for round_timer_ctrl with a behavioural round model
module tb_round_timer_ctrl;

    localparam int WIDTH = 6;

    logic             clock = 1'b0;
    logic             reset;
    logic             second_tick;
    logic             start;
    logic             pause;
    logic             ack;
    logic [WIDTH-1:0] time_limit;
    logic [WIDTH-1:0] remaining;
    logic [3:0]       tens;
    logic [3:0]       units;
    logic             running;
    logic             expired;
    logic             timeout_pulse;

    int tests = 0;
    int fails = 0;

    // Model: phase of the round and seconds left
    typedef enum int {M_IDLE, M_RUN, M_HOLD, M_DONE} mphase_t;
    mphase_t m_phase;
    int      m_left;
    int      m_pulse;

    always #5 clock = ~clock;

    round_timer_ctrl #(
        .WIDTH         (WIDTH),
        .DEFAULT_LIMIT (32)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .second_tick   (second_tick),
        .start         (start),
        .pause         (pause),
        .ack           (ack),
        .time_limit    (time_limit),
        .remaining     (remaining),
        .tens          (tens),
        .units         (units),
        .running       (running),
        .expired       (expired),
        .timeout_pulse (timeout_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("remaining", 32'(remaining), m_left);
        chk("tens", 32'(tens), m_left / 10);
        chk("units", 32'(units), m_left % 10);
        chk("running", 32'(running), (m_phase == M_RUN) ? 1 : 0);
        chk("expired", 32'(expired), (m_phase == M_DONE) ? 1 : 0);
        chk("timeout_pulse", 32'(timeout_pulse), m_pulse);
    endtask

    task automatic model_reset();
        m_phase = M_IDLE;
        m_left  = 0;
        m_pulse = 0;
    endtask

    // One clock with the given inputs; model advances by the round rules, then outputs are compared
    task automatic step(input bit s, input bit p, input bit t, input bit a, input int tl);
        start       = s;
        pause       = p;
        second_tick = t;
        ack         = a;
        time_limit  = WIDTH'(tl);
        @(posedge clock);
        m_pulse = 0;
        if (s) begin
            m_left  = (tl == 0) ? 32 : tl;
            m_phase = M_RUN;
        end else if (m_phase == M_RUN) begin
            if (p) begin
                m_phase = M_HOLD;
            end else if (t) begin
                m_left = (m_left > 0) ? m_left - 1 : 0;
                if (m_left == 0) begin
                    m_phase = M_DONE;
                    m_pulse = 1;
                end
            end
        end else if (m_phase == M_HOLD) begin
            if (!p) m_phase = M_RUN;
        end else if (m_phase == M_DONE) begin
            if (a) begin
                m_phase = M_IDLE;
                m_left  = 0;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        pause       = 1'b0;
        second_tick = 1'b0;
        ack         = 1'b0;
        time_limit  = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all();
        reset = 1'b0;

        // Ticks and ack in IDLE do nothing
        step(0, 0, 1, 1, 9);
        step(0, 1, 1, 0, 9);

        // Five-second round down to expiry
        step(1, 0, 0, 0, 5);
        chk("load5", 32'(remaining), 5);
        for (int i = 4; i >= 0; i--) begin
            step(0, 0, 1, 0, 5);
            chk("count5", 32'(remaining), i);
        end
        chk("pulse_at_expiry", 32'(timeout_pulse), 1);
        chk("expired_flag", 32'(expired), 1);
        step(0, 0, 1, 0, 5);
        chk("pulse_one_cycle", 32'(timeout_pulse), 0);
        chk("hold_zero", 32'(remaining), 0);

        // ack returns to IDLE; later ticks are ignored
        step(0, 0, 0, 1, 5);
        chk("ack_idle_expired", 32'(expired), 0);
        repeat (3) step(0, 0, 1, 0, 5);
        chk("idle_no_count", 32'(remaining), 0);

        // time_limit 0 selects the default
        step(1, 0, 0, 0, 0);
        chk("default_rem", 32'(remaining), 32);
        chk("default_tens", 32'(tens), 3);
        chk("default_units", 32'(units), 2);

        // Pause freezes the count; the release cycle drops its tick
        step(1, 0, 0, 0, 10);
        repeat (3) step(0, 0, 1, 0, 10);
        repeat (4) begin
            step(0, 1, 1, 0, 10);
            chk("paused_rem", 32'(remaining), 7);
        end
        step(0, 0, 1, 0, 10);
        chk("release_tick_dropped", 32'(remaining), 7);
        step(0, 0, 1, 0, 10);
        chk("after_pause", 32'(remaining), 6);

        // start beats a coincident tick, and reloads mid-round
        step(1, 0, 1, 0, 20);
        chk("start_tick", 32'(remaining), 20);
        repeat (17) step(0, 0, 1, 0, 20);
        chk("down_to_3", 32'(remaining), 3);
        step(1, 0, 1, 0, 20);
        chk("reload", 32'(remaining), 20);

        // Reset between edges at remaining 2 clears everything at once
        repeat (18) step(0, 0, 1, 0, 20);
        chk("at_2", 32'(remaining), 2);
        second_tick = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clock);
        #1;
        check_all();
        reset = 1'b0;
        repeat (4) step(0, 0, 1, 0, 20);
        chk("no_pulse_after_reset", 32'(timeout_pulse), 0);

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(15) == 0), ($urandom_range(3) == 0),
                 ($urandom_range(1) == 0), ($urandom_range(3) == 0),
                 int'($urandom_range(63)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
